// File: rtl/tenkey_scanner.sv
// tenkey_scanner: synchronises and debounces raw keypad lines into a one-hot tenkey code.
// Ports: clk, reset (async high), sw_raw[9:0] in; tenkey[9:0], key_code[3:0], key_valid, multi_err, busy out.
// Optional auto-repeat while a key is held: define TENKEY_REPEAT_EN.
module tenkey_scanner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned REPEAT_CYCLES   = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sw_raw,
  output logic [9:0] tenkey,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       multi_err,
  output logic       busy
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W - 1)) begin : g_db_chk
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > (2**CNT_W - 1)) begin : g_rp_chk
    $error("REPEAT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef TENKEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  state_e            state_q, state_d;
  logic [9:0]        meta_q, sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [9:0]        cand_q, cand_d;
  logic [9:0]        tenkey_q, tenkey_d;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic              multi_q;

  logic              sync_multi;
  logic              sync_one;
  logic [3:0]        cand_enc;

  // Clearing the lowest set bit leaves something only when 2+ bits are set.
  assign sync_multi = |(sync_q & (sync_q - 10'd1));
  assign sync_one   = (sync_q != '0) && !sync_multi;

  // Candidate is one-hot whenever it is encoded, so a plain scan suffices.
  always_comb begin
    cand_enc = '0;
    for (int i = 0; i < 10; i++) begin
      if (cand_q[i]) cand_enc = 4'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    tenkey_d = tenkey_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_one) begin
          cand_d  = sync_q;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sync_q != cand_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          cnt_d    = '0;
          tenkey_d = cand_q;
          code_d   = cand_enc;
          valid_d  = 1'b1;
          state_d  = PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (sync_q != cand_q) begin
          tenkey_d = '0;
          cnt_d    = '0;
          state_d  = RELEASE;
        end else begin
`ifdef TENKEY_REPEAT_EN
          if (cnt_q == RP_LAST) begin
            cnt_d   = '0;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      RELEASE: begin
        if (sync_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      tenkey_q <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      meta_q   <= sw_raw;
      sync_q   <= meta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      tenkey_q <= tenkey_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      multi_q  <= sync_multi;
    end
  end

  assign tenkey    = tenkey_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign multi_err = multi_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tenkey_scanner.sv
// tb_tenkey_scanner: directed scenarios plus randomized traffic against a run-length model.
// Build with TENKEY_REPEAT_EN defined to also exercise auto-repeat.
module tb_tenkey_scanner;

  localparam int DB = 4;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sw_raw;
  logic [9:0] tenkey;
  logic [3:0] key_code;
  logic       key_valid;
  logic       multi_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  tenkey_scanner #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(8),
    .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .tenkey(tenkey),
    .key_code(key_code),
    .key_valid(key_valid),
    .multi_err(multi_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Reference model: input pipe plus run-length bookkeeping.
  logic [9:0] p0, p1;
  bit         m_hold, m_rel;
  int         run_len, zero_len, hold_len;
  logic [9:0] run_val;
  logic [9:0] m_key;
  logic [3:0] m_code;
  logic       m_valid, m_multi, m_busy;

  function automatic int ones(input logic [9:0] v);
    int n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [3:0] idx(input logic [9:0] v);
    logic [3:0] r = 4'hf;
    for (int i = 0; i < 10; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic model_reset();
    p0 = '0; p1 = '0;
    m_hold = 0; m_rel = 0;
    run_len = 0; zero_len = 0; hold_len = 0;
    run_val = '0; m_key = '0; m_code = '0;
    m_valid = 0; m_multi = 0; m_busy = 0;
  endtask

  task automatic model_edge(input logic [9:0] v);
    logic [9:0] s;
    s = p1; p1 = p0; p0 = v;
    m_multi = (ones(s) >= 2);
    m_valid = 0;
    if (m_hold) begin
      if (s != m_key) begin
        m_key = '0; m_hold = 0; m_rel = 1; zero_len = 0;
      end else begin
`ifdef TENKEY_REPEAT_EN
        hold_len++;
        if (hold_len == RP) begin
          hold_len = 0; m_valid = 1;
        end
`endif
      end
    end else if (m_rel) begin
      if (s == '0) zero_len++;
      else zero_len = 0;
      if (zero_len == DB) begin
        m_rel = 0; run_len = 0;
      end
    end else begin
      if (run_len > 0 && s == run_val) run_len++;
      else if (run_len > 0) run_len = 0;
      else if (ones(s) == 1) begin
        run_len = 1; run_val = s;
      end
      if (run_len == DB + 1) begin
        m_key = run_val; m_code = idx(run_val);
        m_valid = 1; m_hold = 1; hold_len = 0; run_len = 0;
      end
    end
    m_busy = m_hold || m_rel || (run_len > 0);
  endtask

  task automatic tick(input logic [9:0] v);
    sw_raw = v;
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sw_raw = '0;
    #3;
    checks++;
    if ({tenkey, key_code, key_valid, multi_err, busy} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0",
               {tenkey, key_code, key_valid, multi_err, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_latency();
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      tick(10'h080);
      checks++;
      if (key_valid !== (e == 7)) begin
        errors++;
        $display("FAIL lat_valid e%0d: got %b want %b", e, key_valid, e == 7);
      end
      checks++;
      if (busy !== (e >= 3)) begin
        errors++;
        $display("FAIL lat_busy e%0d: got %b want %b", e, busy, e >= 3);
      end
    end
    checks++;
    if (tenkey !== 10'h080 || key_code !== 4'h7) begin
      errors++;
      $display("FAIL lat_key: got %h/%h want 080/7", tenkey, key_code);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(((i / 2) % 2 == 0) ? 10'h004 : 10'h000);
      checks++;
      if (key_valid !== 1'b0 || tenkey !== 10'h0) begin
        errors++;
        $display("FAIL bounce_i%0d: got %b/%h want 0/000", i, key_valid, tenkey);
      end
    end
    repeat (4) tick(10'h000);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_multi();
    bit got = 0;
    do_reset();
    repeat (20) begin
      tick(10'h001);
      if (key_valid) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || tenkey !== 10'h001) begin
      errors++;
      $display("FAIL multi_accept: got %b/%h want 1/001", got, tenkey);
    end
    tick(10'h009);
    tick(10'h009);
    checks++;
    if (tenkey !== 10'h001 || multi_err !== 1'b0) begin
      errors++;
      $display("FAIL multi_early: got %h/%b want 001/0", tenkey, multi_err);
    end
    tick(10'h009);
    checks++;
    if (tenkey !== 10'h000 || multi_err !== 1'b1) begin
      errors++;
      $display("FAIL multi_drop: got %h/%b want 000/1", tenkey, multi_err);
    end
    for (int i = 0; i < 8; i++) begin
      tick((i < 5) ? 10'h009 : 10'h001);
      checks++;
      if (key_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL multi_hold i%0d: got %b/%b want 0/1", i, key_valid, busy);
      end
    end
    // release: 2 sync edges + DB zero edges before idle
    for (int e = 1; e <= DB + 3; e++) begin
      tick(10'h000);
      checks++;
      if (busy !== (e < DB + 2) || key_valid !== 1'b0) begin
        errors++;
        $display("FAIL multi_rel e%0d: got %b/%b want %b/0",
                 e, busy, key_valid, e < DB + 2);
      end
    end
  endtask

  task automatic press_until_valid(input logic [9:0] v, output bit got);
    got = 0;
    repeat (20) begin
      tick(v);
      if (key_valid) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic test_two_keys();
    bit got;
    do_reset();
    press_until_valid(10'h200, got);
    checks++;
    if (!got || key_code !== 4'h9 || tenkey !== 10'h200) begin
      errors++;
      $display("FAIL two_k9: got %b/%h/%h want 1/9/200", got, key_code, tenkey);
    end
    repeat (10) tick(10'h000);
    press_until_valid(10'h002, got);
    checks++;
    if (!got || key_code !== 4'h1 || tenkey !== 10'h002) begin
      errors++;
      $display("FAIL two_k1: got %b/%h/%h want 1/1/002", got, key_code, tenkey);
    end
    repeat (10) tick(10'h000);
    checks++;
    if (key_code !== 4'h1 || tenkey !== 10'h000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL two_hold: got %h/%h/%b want 1/000/0", key_code, tenkey, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int n = 0;
    do_reset();
    press_until_valid(10'h010, got);
    tick(10'h010);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({tenkey, key_code, key_valid, multi_err, busy} !== 17'h0) begin
      errors++;
      $display("FAIL rmid_outs: got %h want 0",
               {tenkey, key_code, key_valid, multi_err, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    got = 0;
    repeat (20) begin
      tick(10'h010);
      n++;
      if (key_valid) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || n != 3 + DB || tenkey !== 10'h010) begin
      errors++;
      $display("FAIL rmid_relatch: got %b/%0d/%h want 1/%0d/010",
               got, n, tenkey, 3 + DB);
    end
    repeat (10) tick(10'h000);
  endtask

`ifdef TENKEY_REPEAT_EN
  task automatic test_repeat();
    bit got;
    int pulses = 0;
    do_reset();
    press_until_valid(10'h020, got);
    for (int i = 0; i < 40; i++) begin
      tick(10'h020);
      if (key_valid) pulses++;
      checks++;
      if (tenkey !== 10'h020 || key_code !== 4'h5) begin
        errors++;
        $display("FAIL rep_key i%0d: got %h/%h want 020/5", i, tenkey, key_code);
      end
    end
    checks++;
    if (!got || pulses != 5) begin
      errors++;
      $display("FAIL rep_count: got %b/%0d want 1/5", got, pulses);
    end
    repeat (10) tick(10'h000);
  endtask
`endif

  task automatic test_random();
    logic [9:0] v;
    int len, kind;
    do_reset();
    for (int seg = 0; seg < 300; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) v = '0;
      else if (kind < 8) v = 10'(1) << $urandom_range(0, 9);
      else v = 10'($urandom);
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        tick(v);
        checks++;
        if (tenkey !== m_key || key_valid !== m_valid) begin
          errors++;
          $display("FAIL rnd_key s%0d: got %h/%b want %h/%b",
                   seg, tenkey, key_valid, m_key, m_valid);
        end
        checks++;
        if (key_code !== m_code || multi_err !== m_multi || busy !== m_busy) begin
          errors++;
          $display("FAIL rnd_misc s%0d: got %h/%b/%b want %h/%b/%b",
                   seg, key_code, multi_err, busy, m_code, m_multi, m_busy);
        end
        checks++;
        if (ones(tenkey) > 1) begin
          errors++;
          $display("FAIL rnd_onehot s%0d: got %h want <=1 bit", seg, tenkey);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_bounce();
    test_multi();
    test_two_keys();
    test_reset_mid();
`ifdef TENKEY_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tenkey_scanner.md
Name: tenkey_scanner

Overview:
- Front end that drives the one-hot 10-bit tenkey bus consumed by the electronic lock controller.
- Takes raw, asynchronous, bouncing keypad switch lines and synchronises and debounces them.
- Rejects multi-key presses.
- Presents a clean one-hot `tenkey` code, its 4-bit encoded value, and a single-cycle press strobe.

Parameters:
- DEBOUNCE_CYCLES, 16: number of consecutive stable cycles required to accept a press or a release. Legal range 1..(2^CNT_W - 1).
- CNT_W, 8: width of the debounce/repeat counter.
- REPEAT_CYCLES, 200: auto-repeat period in cycles. Used only with TENKEY_REPEAT_EN. Legal range 1..(2^CNT_W - 1).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- sw_raw  input  10  raw keypad switches, bit n = digit n, active-high, asynchronous
- tenkey  output  10  debounced one-hot key, all-zero when no accepted key
- key_code  output  4  binary digit of the accepted key (0..9), holds last value after release
- key_valid  output  1  one-cycle strobe on key acceptance
- multi_err  output  1  registered flag, high while two or more synchronised switch bits are set
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - sync flops = 0, state = IDLE, counter = 0, candidate = 0.
  - tenkey = 0, key_code = 4'h0, key_valid = 0, multi_err = 0, busy = 0.
- Synchroniser: two flops on sw_raw giving `sync`. All decisions below use `sync` only.
- multi_err is registered each cycle as (popcount(sync) >= 2), independent of state.
- IDLE:
  - sync exactly one-hot → candidate <= sync, counter <= 0, go to DEBOUNCE.
  - sync zero or multi-hot → stay in IDLE.
- DEBOUNCE:
  - sync != candidate → go to IDLE, counter <= 0. This covers bounce, a second key, and release.
  - sync == candidate and counter == DEBOUNCE_CYCLES-1 → go to PRESSED; tenkey <= candidate; key_code <= encoded candidate; key_valid <= 1 for exactly one cycle.
  - Otherwise counter++.
- PRESSED:
  - tenkey is held.
  - sync != candidate (release or any additional key) → tenkey <= 0 on the same edge, counter <= 0, go to RELEASE.
- RELEASE:
  - sync != 0 → counter <= 0, stay in RELEASE.
  - sync == 0 and counter == DEBOUNCE_CYCLES-1 → go to IDLE.
  - Otherwise counter++.
  - A new key is accepted only after a full debounced release.
- Latency:
  - A stable press that appears before edge 0 sets tenkey and key_valid after edge 3+DEBOUNCE_CYCLES (edges 1-2 synchronise, edge 3 enters DEBOUNCE).
  - tenkey drops after edge 3 following a stable release.
- Encoding: bit n → 4'hn. Only one-hot values are ever encoded, so there is no default case.
- Simultaneous events:
  - A second key pressed during DEBOUNCE aborts the candidate; no key is accepted.
  - A second key during PRESSED forces RELEASE.
- Reset mid-operation: everything returns to reset values immediately. A key still held after reset is treated as a fresh press with full synchroniser and debounce latency.
- tenkey is always either all-zero or exactly one-hot.

Optional Feature:
- Macro TENKEY_REPEAT_EN.
- Defined:
  - In PRESSED the counter runs; when it reaches REPEAT_CYCLES-1 it wraps to 0 and key_valid pulses for one cycle.
  - tenkey and key_code are unchanged.
  - The counter starts at 0 on entry to PRESSED.
- Undefined:
  - Exactly one key_valid pulse per accepted press.
  - The counter stays idle in PRESSED.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
- Reset, sw_raw=10'h080 held from cycle 0 → tenkey=10'h080, key_code=4'h7, key_valid high for one cycle after edge 7; busy=1 from edge 3.
- sw_raw toggles 10'h004/0 every 2 cycles for 20 cycles, then 0 → tenkey stays 0, key_valid never asserted, ends in IDLE.
- Press 10'h001 until accepted, then add bit 3 (sw_raw=10'h009) → multi_err=1, tenkey=0 three cycles later, no new key_valid until all keys are released for 4 cycles.
- Press 10'h200, release, press 10'h002 → two key_valid pulses, key_code 4'h9 then 4'h1, key_code holds 4'h1 after release.
- Assert reset while in PRESSED with the key held → outputs go to 0 immediately; after deassertion the key is re-accepted after 3+4 edges.
- With TENKEY_REPEAT_EN defined, hold 10'h020 for 40 cycles after acceptance → key_valid pulses at acceptance then every 8 cycles (5 repeats); tenkey stays 10'h020.
